// File: rtl/matrix_accel_sequencer.sv
// matrix_accel_sequencer
// Command-driven controller for the matrixAccelerator datapath. A job clears the
// accumulators, feeds N operand beats (load, mStart pulse, Add pulse per beat),
// then reads READ_COUNT result buffer addresses and streams them out.
//
// Ports:
//   Clk, Rst                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready      job handshake, cmd_beats = operand beats in the job
//   op_valid/op_ready        operand-beat handshake, op_multiplier/op_multiplicand lanes
//   acc_*                    accelerator controls, address and registered operands
//   acc_flatsumout           accelerator result bus
//   res_valid/res_ready      result handshake, res_data captured result, res_last final
//   busy                     high whenever the sequencer is not idle
module matrix_accel_sequencer #(
  parameter int BIT_LEN     = 16,
  parameter int IN_PORTS    = 4,
  parameter int OUT_PORTS   = 4,
  parameter int ADDR_LEN    = 4,
  parameter int MAX_BEATS   = 15,
  parameter int READ_COUNT  = 4,
  parameter int ADDR_BASE   = 3,
  parameter int ADDR_STRIDE = 3,
  parameter int REST_ADDR   = 0,
  parameter int RD_LAT      = 1
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [$clog2(MAX_BEATS+1)-1:0]    cmd_beats,
  input  logic                              op_valid,
  output logic                              op_ready,
  input  logic [IN_PORTS*BIT_LEN-1:0]       op_multiplier,
  input  logic [IN_PORTS*BIT_LEN-1:0]       op_multiplicand,
  output logic                              acc_rst,
  output logic                              acc_mStart,
  output logic                              acc_Add,
  output logic                              acc_direct,
  output logic                              acc_bufferRD,
  output logic [ADDR_LEN-1:0]               acc_AddressSelect,
  output logic [IN_PORTS*BIT_LEN-1:0]       acc_multiplier,
  output logic [IN_PORTS*BIT_LEN-1:0]       acc_multiplicand,
  input  logic [OUT_PORTS*2*BIT_LEN-1:0]    acc_flatsumout,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [OUT_PORTS*2*BIT_LEN-1:0]    res_data,
  output logic                              res_last,
  output logic                              busy
);

  localparam int BEAT_W = $clog2(MAX_BEATS+1);
  localparam int K_W    = (READ_COUNT > 1) ? $clog2(READ_COUNT) : 1;
  localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int OP_W   = IN_PORTS*BIT_LEN;
  localparam int RES_W  = OUT_PORTS*2*BIT_LEN;

  localparam logic [BEAT_W-1:0]   BEATS_ZERO = {BEAT_W{1'b0}};
  localparam logic [BEAT_W-1:0]   BEATS_ONE  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0]   BEATS_MAX  = BEAT_W'(MAX_BEATS);
  localparam logic [K_W-1:0]      K_ZERO     = {K_W{1'b0}};
  localparam logic [K_W-1:0]      K_ONE      = K_W'(1);
  localparam logic [K_W-1:0]      K_LAST     = K_W'(READ_COUNT-1);
  localparam logic [LAT_W-1:0]    LAT_ZERO   = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0]    LAT_ONE    = LAT_W'(1);
  localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(RD_LAT-1);
  localparam logic [ADDR_LEN-1:0] REST_V     = ADDR_LEN'(REST_ADDR);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_ADD    = 3'd4;
  localparam logic [2:0] S_RDADDR = 3'd5;
  localparam logic [2:0] S_RDWAIT = 3'd6;
  localparam logic [2:0] S_RDOUT  = 3'd7;

  logic [2:0]        state_r, state_next_s;
  logic [BEAT_W-1:0] beats_r, beats_next_s, beat_cnt_r, beat_cnt_next_s, beats_sat_s, beat_inc_s;
  logic [K_W-1:0]    k_r, k_next_s;
  logic [LAT_W-1:0]  lat_r, lat_next_s;
  logic              op_capture_s, res_capture_s;
  logic [31:0]       rd_addr_full_s;
  logic [ADDR_LEN-1:0] rd_addr_s;

  // Oversized beat requests clamp to MAX_BEATS; only needed when the port can exceed it.
  if (((2**BEAT_W) - 1) > MAX_BEATS) begin : g_sat
    assign beats_sat_s = (cmd_beats > BEATS_MAX) ? BEATS_MAX : cmd_beats;
  end else begin : g_nosat
    assign beats_sat_s = cmd_beats;
  end

  assign beat_inc_s     = beat_cnt_r + BEATS_ONE;
  assign rd_addr_full_s = 32'(ADDR_BASE) + (32'(k_next_s) * 32'(ADDR_STRIDE));
  assign rd_addr_s      = rd_addr_full_s[ADDR_LEN-1:0];

  // Next-state, counters and capture strobes. Handshakes use the registered
  // ready/valid outputs so nothing is accepted in the cycle right after reset release.
  always_comb begin
    state_next_s    = state_r;
    beats_next_s    = beats_r;
    beat_cnt_next_s = beat_cnt_r;
    k_next_s        = k_r;
    lat_next_s      = lat_r;
    op_capture_s    = 1'b0;
    res_capture_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cmd_ready && cmd_valid) begin
          beats_next_s    = beats_sat_s;
          beat_cnt_next_s = BEATS_ZERO;
          k_next_s        = K_ZERO;
          state_next_s    = S_CLEAR;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (beats_r != BEATS_ZERO) begin
          state_next_s = S_FETCH;
        end else begin
          lat_next_s   = LAT_ZERO;
          state_next_s = S_RDADDR;
        end
      end
      S_FETCH: begin
        if (op_ready && op_valid) begin
          op_capture_s = 1'b1;
          state_next_s = S_START;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_START: state_next_s = S_ADD;
      S_ADD: begin
        beat_cnt_next_s = beat_inc_s;
        if (beat_inc_s < beats_r) begin
          state_next_s = S_FETCH;
        end else begin
          lat_next_s   = LAT_ZERO;
          state_next_s = S_RDADDR;
        end
      end
      S_RDADDR, S_RDWAIT: begin
        // lat_r counts cycles since the address was first presented.
        if (lat_r == LAT_LAST) begin
          res_capture_s = 1'b1;
          state_next_s  = S_RDOUT;
        end else begin
          lat_next_s   = lat_r + LAT_ONE;
          state_next_s = S_RDWAIT;
        end
      end
      S_RDOUT: begin
        if (res_valid && res_ready) begin
          if (res_last) begin
            state_next_s = S_IDLE;
          end else begin
            k_next_s     = k_r + K_ONE;
            lat_next_s   = LAT_ZERO;
            state_next_s = S_RDADDR;
          end
        end else begin
          state_next_s = S_RDOUT;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State and job counters.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r    <= S_IDLE;
      beats_r    <= BEATS_ZERO;
      beat_cnt_r <= BEATS_ZERO;
      k_r        <= K_ZERO;
      lat_r      <= LAT_ZERO;
    end else begin
      state_r    <= state_next_s;
      beats_r    <= beats_next_s;
      beat_cnt_r <= beat_cnt_next_s;
      k_r        <= k_next_s;
      lat_r      <= lat_next_s;
    end
  end

  // Control outputs are registered from the next state so each matches the state it belongs to.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cmd_ready         <= 1'b0;
      op_ready          <= 1'b0;
      acc_rst           <= 1'b1;
      acc_mStart        <= 1'b0;
      acc_Add           <= 1'b0;
      acc_direct        <= 1'b0;
      acc_bufferRD      <= 1'b0;
      acc_AddressSelect <= REST_V;
      res_valid         <= 1'b0;
      res_last          <= 1'b0;
      busy              <= 1'b0;
    end else begin
      cmd_ready         <= (state_next_s == S_IDLE);
      op_ready          <= (state_next_s == S_FETCH);
      acc_rst           <= (state_next_s == S_CLEAR);
      acc_mStart        <= (state_next_s == S_START);
      acc_Add           <= (state_next_s == S_ADD);
      acc_direct        <= (state_next_s == S_FETCH) || (state_next_s == S_START) ||
                           (state_next_s == S_ADD);
      acc_bufferRD      <= (state_next_s == S_RDADDR) || (state_next_s == S_RDWAIT);
      acc_AddressSelect <= ((state_next_s == S_RDADDR) || (state_next_s == S_RDWAIT)) ?
                           rd_addr_s : REST_V;
      res_valid         <= (state_next_s == S_RDOUT);
      res_last          <= (state_next_s == S_RDOUT) && (k_next_s == K_LAST);
      busy              <= (state_next_s != S_IDLE);
    end
  end

  // Operand and result holding registers; each only changes on its capture strobe.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      acc_multiplier   <= {OP_W{1'b0}};
      acc_multiplicand <= {OP_W{1'b0}};
      res_data         <= {RES_W{1'b0}};
    end else begin
      if (op_capture_s) begin
        acc_multiplier   <= op_multiplier;
        acc_multiplicand <= op_multiplicand;
      end
      if (res_capture_s) begin
        res_data <= acc_flatsumout;
      end
    end
  end

endmodule

// File: tb/tb_matrix_accel_sequencer.sv
// Self-checking bench for matrix_accel_sequencer: a table of jobs plus directed
// sequences for exact cycle timing and mid-job reset. A stub accelerator returns
// data equal to the presented address replicated across the result bus; expected
// results are queued when a job is issued and popped on each result handshake.
module tb_matrix_accel_sequencer;

  localparam int OPW = 64;
  localparam int RW  = 128;

  logic           Clk;
  logic           Rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [3:0]     cmd_beats;
  logic           op_valid;
  logic           op_ready;
  logic [OPW-1:0] op_multiplier;
  logic [OPW-1:0] op_multiplicand;
  logic           acc_rst, acc_mStart, acc_Add, acc_direct, acc_bufferRD;
  logic [3:0]     acc_AddressSelect;
  logic [OPW-1:0] acc_multiplier, acc_multiplicand;
  logic [RW-1:0]  acc_flatsumout;
  logic           res_valid, res_ready, res_last, busy;
  logic [RW-1:0]  res_data;

  matrix_accel_sequencer #(
    .BIT_LEN(16), .IN_PORTS(4), .OUT_PORTS(4), .ADDR_LEN(4), .MAX_BEATS(15),
    .READ_COUNT(4), .ADDR_BASE(3), .ADDR_STRIDE(3), .REST_ADDR(0), .RD_LAT(1)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_beats(cmd_beats),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_multiplier(op_multiplier), .op_multiplicand(op_multiplicand),
    .acc_rst(acc_rst), .acc_mStart(acc_mStart), .acc_Add(acc_Add),
    .acc_direct(acc_direct), .acc_bufferRD(acc_bufferRD),
    .acc_AddressSelect(acc_AddressSelect),
    .acc_multiplier(acc_multiplier), .acc_multiplicand(acc_multiplicand),
    .acc_flatsumout(acc_flatsumout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .busy(busy)
  );

  // Accelerator stub: result data equals the address, replicated.
  assign acc_flatsumout = {32{acc_AddressSelect}};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [RW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    int beats;
    int delay;
    int stall;
    int exp_pulses;
  } vec_t;

  exp_t           sb[$];
  vec_t           vecs[6];
  logic [3:0]     rd_addrs[4];
  int             n_vec, n_err;
  int             mstart_cnt, add_cnt, clr_cnt;
  logic           prev_mstart, prev_stall;
  logic [RW-1:0]  prev_data;
  logic [OPW-1:0] exp_mul, exp_mcand;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, RW'(act), RW'(exp));
  endtask

  // Per-cycle observation at the falling edge: pulse rules, hold under backpressure, scoreboard.
  task automatic sample();
    exp_t e;
    @(negedge Clk);
    if (Rst) begin
      if (acc_mStart) begin
        mstart_cnt++;
        check("mstart_shape", RW'({acc_Add, acc_direct, prev_mstart}), RW'(3'b010));
        check("op_multiplier", RW'(acc_multiplier), RW'(exp_mul));
        check("op_multiplicand", RW'(acc_multiplicand), RW'(exp_mcand));
      end
      if (acc_Add) begin
        add_cnt++;
        check("add_shape", RW'({acc_mStart, acc_direct, prev_mstart}), RW'(3'b011));
      end
      if (acc_rst) clr_cnt++;
      if (prev_stall) begin
        check1("hold_valid", res_valid, 1'b1);
        check("hold_data", res_data, prev_data);
      end
      if (res_valid && !res_ready)
        check("stall_no_addr", RW'({acc_bufferRD, acc_AddressSelect}), RW'(5'b0));
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_result: got %0h expected none", res_data);
        end else begin
          e = sb.pop_front();
          check("res_data", res_data, e.data);
          check1("res_last", res_last, e.last);
        end
      end
      prev_mstart = acc_mStart;
      prev_stall  = res_valid && !res_ready;
      prev_data   = res_data;
    end else begin
      prev_mstart = 1'b0;
      prev_stall  = 1'b0;
    end
  endtask

  task automatic step();
    sample();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_exp();
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.data = {32{rd_addrs[k]}};
      e.last = (k == 3);
      sb.push_back(e);
    end
  endtask

  task automatic send_cmd(input int beats);
    int t = 0;
    while (!cmd_ready && t < 20) begin step(); t++; end
    if (!cmd_ready) begin
      n_vec++; n_err++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
    end
    cmd_beats = 4'(beats);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic feed_beat(input int delay);
    int t = 0;
    repeat (delay) step();
    exp_mul         = {$urandom, $urandom};
    exp_mcand       = {$urandom, $urandom};
    op_multiplier   = exp_mul;
    op_multiplicand = exp_mcand;
    op_valid        = 1'b1;
    while (!op_ready && t < 20) begin step(); t++; end
    if (!op_ready) begin
      n_vec++; n_err++;
      $display("FAIL op_ready_timeout: got 0 expected 1");
    end
    step();
    op_valid = 1'b0;
    step();
    step();
  endtask

  task automatic collect(input int stall);
    for (int r = 0; r < 4; r++) begin
      int t = 0;
      while (!res_valid && t < 50) begin step(); t++; end
      if (!res_valid) begin
        n_vec++; n_err++;
        $display("FAIL res_valid_timeout: got 0 expected 1 (read %0d)", r);
        return;
      end
      if (stall > 0) begin
        res_ready = 1'b0;
        repeat (stall) step();
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
    end
  endtask

  task automatic run_job(input vec_t v);
    int m0, a0, c0;
    push_exp();
    m0 = mstart_cnt; a0 = add_cnt; c0 = clr_cnt;
    send_cmd(v.beats);
    for (int b = 0; b < v.beats; b++) feed_beat(v.delay);
    collect(v.stall);
    step();
    check("sb_drained", RW'(sb.size()), RW'(0));
    check("mstart_pulses", RW'(mstart_cnt - m0), RW'(v.exp_pulses));
    check("add_pulses", RW'(add_cnt - a0), RW'(v.exp_pulses));
    check("clear_cycles", RW'(clr_cnt - c0), RW'(1));
    check("idle_after_job", RW'({busy, cmd_ready}), RW'(2'b01));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl"}, RW'({acc_rst, acc_mStart, acc_Add, acc_direct, acc_bufferRD}), RW'(5'b10000));
    check({tag, "_addr"}, RW'(acc_AddressSelect), RW'(4'd0));
    check({tag, "_hs"}, RW'({cmd_ready, op_ready, res_valid, res_last, busy}), RW'(5'b0));
    check({tag, "_ops"}, RW'({acc_multiplier, acc_multiplicand}), RW'(0));
    check({tag, "_res_data"}, res_data, RW'(0));
  endtask

  task automatic quiet_after_release();
    Rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check1("no_valid_after_reset", res_valid, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t dv;
    n_vec = 0; n_err = 0;
    mstart_cnt = 0; add_cnt = 0; clr_cnt = 0;
    prev_mstart = 1'b0; prev_stall = 1'b0; prev_data = '0;
    exp_mul = '0; exp_mcand = '0;
    rd_addrs[0] = 4'd3; rd_addrs[1] = 4'd6; rd_addrs[2] = 4'd9; rd_addrs[3] = 4'd12;
    vecs[0] = '{1, 0, 0, 1};
    vecs[1] = '{3, 2, 0, 3};
    vecs[2] = '{2, 0, 4, 2};
    vecs[3] = '{0, 0, 0, 0};
    vecs[4] = '{15, 1, 1, 15};
    vecs[5] = '{4, 3, 2, 4};

    Rst = 1'b0; cmd_valid = 1'b0; cmd_beats = 4'd0; op_valid = 1'b0;
    op_multiplier = '0; op_multiplicand = '0; res_ready = 1'b0;

    // Reset state, then idle after release.
    repeat (3) step();
    check_reset_values("reset");
    Rst = 1'b1;
    repeat (5) step();
    check("idle_state", RW'({acc_rst, acc_AddressSelect, cmd_ready, busy}), RW'(7'b0_0000_10));

    // Directed beats=1 job: exact cycle timing from command acceptance.
    push_exp();
    exp_mul         = {16'h4000, 16'h5a05, 16'h5800, 16'h0003};
    exp_mcand       = {16'h4000, 16'h5027, 16'h4e68, 16'h0001};
    op_multiplier   = exp_mul;
    op_multiplicand = exp_mcand;
    op_valid        = 1'b1;
    cmd_beats       = 4'd1;
    cmd_valid       = 1'b1;
    check1("t_cmd_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    check("t1_clear", RW'({acc_rst, op_ready, busy}), RW'(3'b101));
    step();
    check("t2_fetch", RW'({acc_rst, op_ready, acc_direct, acc_mStart}), RW'(4'b0110));
    step();
    op_valid = 1'b0;
    check("t3_start", RW'({acc_mStart, acc_Add, acc_direct}), RW'(3'b101));
    check("t3_operands", RW'({acc_multiplier, acc_multiplicand}), RW'({exp_mul, exp_mcand}));
    step();
    check("t4_add", RW'({acc_mStart, acc_Add, acc_direct}), RW'(3'b011));
    step();
    check("t5_read", RW'({acc_bufferRD, acc_direct, acc_AddressSelect}), RW'(6'b10_0011));
    collect(0);
    step();
    check("directed_drained", RW'(sb.size()), RW'(0));

    // Table-driven jobs.
    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // Reset during ADD.
    send_cmd(2);
    exp_mul = {$urandom, $urandom}; exp_mcand = {$urandom, $urandom};
    op_multiplier = exp_mul; op_multiplicand = exp_mcand; op_valid = 1'b1;
    begin
      int t = 0;
      while (!op_ready && t < 20) begin step(); t++; end
    end
    step();
    op_valid = 1'b0;
    step();
    check1("in_add", acc_Add, 1'b1);
    #1 Rst = 1'b0;
    #1 check_reset_values("abort_add");
    sb.delete();
    repeat (3) step();
    quiet_after_release();
    dv = '{2, 1, 1, 2};
    run_job(dv);

    // Reset during RDOUT with a result pending.
    send_cmd(0);
    begin
      int t = 0;
      while (!res_valid && t < 20) begin step(); t++; end
    end
    check1("in_rdout", res_valid, 1'b1);
    #1 Rst = 1'b0;
    #1 check_reset_values("abort_rdout");
    repeat (2) step();
    quiet_after_release();
    dv = '{1, 0, 0, 1};
    run_job(dv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
